// File: rtl/pr_bus_pkg.sv
// pr_bus_pkg: shared state encoding, default device windows and master indices for the Pr* device bus
package pr_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  localparam logic [31:0] D0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] D1_BASE_DEF = 32'h0000_7F10;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/pr_addr_decode.sv
// pr_addr_decode: byte address -> one-hot device select (3-word windows) plus miss flag
//   addr in W : byte address, bits [1:0] ignored
//   sel  out 2: one-hot device select
//   miss out 1: address hits neither window
module pr_addr_decode import pr_bus_pkg::*; #(
  parameter int W = 32,
  parameter logic [W-1:0] D0_BASE = W'(D0_BASE_DEF),
  parameter logic [W-1:0] D1_BASE = W'(D1_BASE_DEF)
) (
  input  logic [W-1:0] addr,
  output logic [1:0]   sel,
  output logic         miss
);
  logic [W-1:0] aw, o0, o1;
  // unsigned offsets wrap for addresses below a base, so one compare covers both edges
  assign aw   = addr & ~W'(3);
  assign o0   = aw - D0_BASE;
  assign o1   = aw - D1_BASE;
  assign sel  = {o1 < W'(12), o0 < W'(12)};
  assign miss = ~|sel;
endmodule

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: two-master round-robin arbiter for the Pr* device bus with decode, ack wait and timeout
//   clk, reset (async active-low)
//   m0_*/m1_*  : req/we/addr/wd in; gnt/done/err/rd out (done-qualified, registered)
//   dev_*      : registered addr/wd/we/sel out; ack and rd0/rd1 in
//   to_irq     : sticky timeout flag
module pr_bus_arbiter import pr_bus_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] D0_BASE = DATA_W'(D0_BASE_DEF),
  parameter logic [DATA_W-1:0] D1_BASE = DATA_W'(D1_BASE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wd,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_err,
  output logic              m1_err,
  output logic [DATA_W-1:0] m0_rd,
  output logic [DATA_W-1:0] m1_rd,
  output logic [DATA_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wd,
  output logic              dev_we,
  output logic [1:0]        dev_sel,
  input  logic [1:0]        dev_ack,
  input  logic [DATA_W-1:0] dev_rd0,
  input  logic [DATA_W-1:0] dev_rd1,
  output logic              to_irq
);
  state_t state;
  logic last, owner, we_l, gnt_r, done_r, err_r, win, we, miss, hit, tmo;
  logic [DATA_W-1:0] rd_r, a, wd, rdata;
  logic [1:0] sel;
  logic [7:0] cnt;
  // tie goes to the master that did not win last
  assign win   = (m0_req & m1_req) ? ~last : m1_req;
  assign a     = win ? m1_addr : m0_addr;
  assign wd    = win ? m1_wd : m0_wd;
  assign we    = win ? m1_we : m0_we;
  assign hit   = |(dev_ack & dev_sel);
  assign rdata = dev_sel[1] ? dev_rd1 : dev_rd0;
  // WAIT starts at cnt=0 one cycle after ISSUE; leave on the cycle that puts DONE TIMEOUT cycles after ISSUE
  assign tmo   = (9'(cnt) + 9'd2) >= 9'(TIMEOUT);
  assign m0_gnt  = gnt_r & (owner == M0);
  assign m1_gnt  = gnt_r & (owner == M1);
  assign m0_done = done_r & (owner == M0);
  assign m1_done = done_r & (owner == M1);
  assign m0_err  = err_r & (owner == M0);
  assign m1_err  = err_r & (owner == M1);
  assign m0_rd   = (owner == M0) ? rd_r : '0;
  assign m1_rd   = (owner == M1) ? rd_r : '0;
  pr_addr_decode #(.W(DATA_W), .D0_BASE(D0_BASE), .D1_BASE(D1_BASE)) u_dec (
    .addr(a),
    .sel(sel),
    .miss(miss)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= M1;
      owner    <= M0;
      we_l     <= 1'b0;
      gnt_r    <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      rd_r     <= '0;
      cnt      <= '0;
      dev_addr <= '0;
      dev_wd   <= '0;
      dev_we   <= 1'b0;
      dev_sel  <= 2'b00;
      to_irq   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      rd_r   <= '0;
      dev_we <= 1'b0;
      case (state)
        IDLE: if (m0_req | m1_req) begin
          owner    <= win;
          we_l     <= we;
          dev_addr <= a;
          dev_wd   <= wd;
          gnt_r    <= 1'b1;
          dev_sel  <= sel;
          dev_we   <= we & ~miss;
          done_r   <= miss;
          err_r    <= miss;
          state    <= miss ? DONE : ISSUE;
        end
        ISSUE, WAIT: if (hit) begin
          state   <= DONE;
          dev_sel <= 2'b00;
          done_r  <= 1'b1;
          rd_r    <= we_l ? '0 : rdata;
        end else if (state == ISSUE) begin
          state <= WAIT;
          cnt   <= '0;
        end else if (tmo) begin
          state   <= DONE;
          dev_sel <= 2'b00;
          done_r  <= 1'b1;
          err_r   <= 1'b1;
          to_irq  <= 1'b1;
        end else
          cnt <= cnt + 8'd1;
        default: begin
          state <= IDLE;
          gnt_r <= 1'b0;
          last  <= owner;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb_pr_bus_arbiter: directed vector table plus back-to-back and reset-in-WAIT sequences
module tb_pr_bus_arbiter;
  localparam int TO = 15;
  localparam logic [31:0] RD0 = 32'hDEAD_BEEF;
  localparam logic [31:0] RD1 = 32'hCAFE_0001;
  logic clk = 0, reset = 0;
  logic m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wd = 0, m1_wd = 0;
  logic m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, dev_we, to_irq;
  logic [31:0] m0_rd, m1_rd, dev_addr, dev_wd;
  logic [1:0] dev_sel;
  logic [1:0] dev_ack = 0;
  logic [31:0] dev_rd0 = RD0, dev_rd1 = RD1;
  int checks = 0, errors = 0;
  int ack_wait = 0, wcnt = 0;
  bit noise = 0;
  typedef struct {
    bit m; bit we; logic [31:0] addr; logic [31:0] wd; int waits; bit noise;
    int lat; logic [31:0] rd; bit err; logic [1:0] esel; int selc; int wec; bit irq;
  } vec_t;
  vec_t tv[8];
  pr_bus_arbiter #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wd(m0_wd), .m1_wd(m1_wd),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err), .m0_rd(m0_rd), .m1_rd(m1_rd),
    .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we), .dev_sel(dev_sel),
    .dev_ack(dev_ack), .dev_rd0(dev_rd0), .dev_rd1(dev_rd1), .to_irq(to_irq)
  );
  always #5 clk = ~clk;
  // device model: selected device acks after ack_wait cycles of select; noise acks the other device
  always @(posedge clk) begin
    #1;
    if (dev_sel != 2'b00) begin
      dev_ack = ((wcnt == ack_wait) ? dev_sel : 2'b00) | (noise ? ~dev_sel : 2'b00);
      wcnt = wcnt + 1;
    end else begin
      dev_ack = 2'b00;
      wcnt = 0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input int idx);
    int n, selc, wec;
    bit seen;
    @(posedge clk); #1;
    ack_wait = v.waits;
    noise = v.noise;
    if (v.m) begin m1_req = 1; m1_we = v.we; m1_addr = v.addr; m1_wd = v.wd; end
    else begin m0_req = 1; m0_we = v.we; m0_addr = v.addr; m0_wd = v.wd; end
    n = 0; selc = 0; wec = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (dev_sel != 2'b00) begin
        selc++;
        if (selc == 1) begin
          chk($sformatf("v%0d dev_sel", idx), 32'(dev_sel), 32'(v.esel));
          chk($sformatf("v%0d dev_addr", idx), dev_addr, v.addr);
          if (v.we) chk($sformatf("v%0d dev_wd", idx), dev_wd, v.wd);
        end
      end
      if (dev_we) wec++;
      if (m0_done | m1_done) begin
        seen = 1;
        chk($sformatf("v%0d done_owner", idx), {30'd0, m1_done, m0_done}, v.m ? 32'd2 : 32'd1);
        chk($sformatf("v%0d gnt", idx), {30'd0, m1_gnt, m0_gnt}, v.m ? 32'd2 : 32'd1);
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.lat));
        chk($sformatf("v%0d rd", idx), v.m ? m1_rd : m0_rd, v.rd);
        chk($sformatf("v%0d err", idx), 32'(v.m ? m1_err : m0_err), 32'(v.err));
        chk($sformatf("v%0d to_irq", idx), 32'(to_irq), 32'(v.irq));
        m0_req = 0; m1_req = 0;
      end
    end
    if (!seen) begin
      chk($sformatf("v%0d done_seen", idx), 32'd0, 32'd1);
      m0_req = 0; m1_req = 0;
    end
    chk($sformatf("v%0d sel_cycles", idx), 32'(selc), 32'(v.selc));
    chk($sformatf("v%0d we_cycles", idx), 32'(wec), 32'(v.wec));
  endtask
  initial begin
    int n, k;
    tv[0] = '{0, 0, 32'h7F04, 32'h0,  0, 0, 2, RD0, 0, 2'b01, 1, 0, 0};
    tv[1] = '{1, 1, 32'h7F18, 32'h12, 4, 0, 6, 32'h0, 0, 2'b10, 5, 1, 0};
    tv[2] = '{0, 0, 32'h7F14, 32'h0,  2, 1, 4, RD1, 0, 2'b10, 3, 0, 0};
    tv[3] = '{1, 0, 32'h7F02, 32'h0,  1, 1, 3, RD0, 0, 2'b01, 2, 0, 0};
    tv[4] = '{0, 0, 32'h1000, 32'h0,  0, 0, 1, 32'h0, 1, 2'b00, 0, 0, 0};
    tv[5] = '{1, 1, 32'h7F0C, 32'h55, 0, 0, 1, 32'h0, 1, 2'b00, 0, 0, 0};
    tv[6] = '{0, 0, 32'h7F08, 32'h0, 255, 0, TO + 1, 32'h0, 1, 2'b01, TO, 0, 1};
    tv[7] = '{0, 0, 32'h7F10, 32'h0,  0, 1, 2, RD1, 0, 2'b10, 1, 0, 1};
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, dev_we, to_irq, dev_sel}, 32'd0);
    chk("reset rd", m0_rd | m1_rd | dev_addr | dev_wd, 32'd0);
    reset = 1;
    for (int i = 0; i < 8; i++) run_vec(tv[i], i);
    chk("to_irq sticky", 32'(to_irq), 32'd1);
    // reset asserted mid-WAIT drops every strobe without a clock
    @(posedge clk); #1;
    ack_wait = 255; noise = 0;
    m1_req = 1; m1_we = 1; m1_addr = 32'h7F00; m1_wd = 32'hA5;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre-reset sel", 32'(dev_sel), 32'd1);
    chk("pre-reset gnt", 32'(m1_gnt), 32'd1);
    #3 reset = 0;
    #1;
    chk("async reset strobes", {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, dev_we, to_irq, dev_sel}, 32'd0);
    chk("async reset addr", dev_addr, 32'd0);
    m1_req = 0; m1_we = 0;
    @(posedge clk); #1;
    chk("reset held idle", {30'd0, m1_gnt, dev_we}, 32'd0);
    reset = 1;
    // both masters hold req: m0 first after reset, then strict alternation every 3 cycles
    ack_wait = 0; noise = 0;
    m0_addr = 32'h7F04; m0_we = 0; m1_addr = 32'h7F14; m1_we = 0;
    m0_req = 1; m1_req = 1;
    n = 0; k = 0;
    while (k < 4 && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (m0_done | m1_done) begin
        chk($sformatf("b2b%0d owner", k), {30'd0, m1_done, m0_done}, (k % 2) ? 32'd2 : 32'd1);
        chk($sformatf("b2b%0d cycle", k), 32'(n), 32'(2 + 3 * k));
        chk($sformatf("b2b%0d rd", k), (k % 2) ? m1_rd : m0_rd, (k % 2) ? RD1 : RD0);
        k++;
        if (k == 4) begin m0_req = 0; m1_req = 0; end
      end
    end
    if (k < 4) chk("b2b done count", 32'(k), 32'd4);
    m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
